if_fetch_ctrl: RTL and testbench

//  Instruction-fetch controller feeding the instruction ROM and the decode stage.

---
 rtl/if_pkg.sv | 20 ++
 rtl/if_pc_next.sv | 26 ++
 rtl/if_fetch_ctrl.sv | 129 ++++++++++++
 tb/tb_if_fetch_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared fetch-stage types: FSM state, next-PC select, PC increment, default halt sentinel.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC4 = 2'd1,
        PC_BR   = 2'd2,
        PC_RST  = 2'd3
    } pc_sel_e;

    localparam logic [31:0] PC_INC         = 32'd4;
    localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/if_pc_next.sv
// Next-PC mux: hold / pc+4 / redirect target / reset vector.
// Purely combinational, 0 cycles; no flow control of its own.
module if_pc_next
    import if_pkg::*;
#(
    parameter int            PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  pc_sel_e          sel_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [PC_W-1:0]  br_target_i,
    output logic [PC_W-1:0]  pc_next_o
);

    always_comb begin
        pc_next_o = pc_i;
        unique case (sel_i)
            PC_HOLD: pc_next_o = pc_i;
            PC_INC4: pc_next_o = pc_i + PC_W'(PC_INC);
            PC_BR:   pc_next_o = br_target_i;
            PC_RST:  pc_next_o = RESET_PC;
            default: pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, registers ROM data into a valid/ready slot.
// Latency: 1 cycle pc -> out_*; stall holds pc and slot while out_valid & !out_ready.
// IF_MISALIGN_TRAP_EN: misaligned redirect traps to HALT with sticky misalign_err.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter int                ADDR_W     = 10,
    parameter int                DATA_W     = 32,
    parameter int                PC_W       = 32,
    parameter logic [PC_W-1:0]   RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_W-1:0] HALT_INSTR = HALT_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    input  logic              br_valid,
    input  logic [PC_W-1:0]   br_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic              halted,
    output logic              misalign_err
);

`ifdef IF_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    fetch_state_e      state_q, state_d;
    pc_sel_e           pc_sel;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_instr_q;
    logic [PC_W-1:0]   out_pc_q;
    logic              halted_q;
    logic              misalign_q, misalign_d;
    logic              capture;
    logic              slot_free;
    logic              misalign_br;
    logic [PC_W-1:0]   br_tgt_al;

    assign slot_free   = !out_valid_q || out_ready;
    assign misalign_br = TRAP_EN && br_valid && (br_target[1:0] != 2'b00);
    // Without the trap, low target bits are silently dropped to keep fetches word aligned.
    assign br_tgt_al   = TRAP_EN ? br_target : {br_target[PC_W-1:2], 2'b00};

    always_comb begin
        state_d     = state_q;
        pc_sel      = PC_HOLD;
        out_valid_d = out_valid_q && !out_ready;
        capture     = 1'b0;
        misalign_d  = misalign_q;

        if (misalign_br) begin
            misalign_d  = 1'b1;
            out_valid_d = 1'b0;
            state_d     = HALT;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (br_valid) pc_sel = PC_BR;
                    if (start)    state_d = RUN;
                end
                HALT: begin
                    if (br_valid)               pc_sel = PC_BR;
                    if (start && !misalign_q)   state_d = RUN;
                end
                RUN: begin
                    if (br_valid) begin
                        pc_sel      = PC_BR;
                        out_valid_d = 1'b0;
                    end else if (slot_free) begin
                        capture     = 1'b1;
                        pc_sel      = PC_INC4;
                        out_valid_d = 1'b1;
                        // The sentinel itself is still handed to decode.
                        if (rom_dout == HALT_INSTR) state_d = HALT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    if_pc_next #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_next (
        .sel_i       (pc_sel),
        .pc_i        (pc_q),
        .br_target_i (br_tgt_al),
        .pc_next_o   (pc_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            halted_q    <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            halted_q    <= (state_d == HALT);
            misalign_q  <= misalign_d;
            if (capture) begin
                out_instr_q <= rom_dout;
                out_pc_q    <= pc_q;
            end
        end
    end

    assign rom_addr     = pc_q[ADDR_W+1:2];
    assign out_valid    = out_valid_q;
    assign out_instr    = out_instr_q;
    assign out_pc       = out_pc_q;
    assign halted       = halted_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a combinational 1024-word ROM model.
module tb_if_fetch_ctrl;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        start     = 1'b0;
    logic        br_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] br_target = '0;
    logic [9:0]  rom_addr;
    logic [31:0] rom_dout;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        misalign_err;

    logic [31:0] rom [1024];
    assign rom_dout = rom[rom_addr];

    int n_tests = 0;
    int n_fail  = 0;

    if_fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rom_addr     (rom_addr),
        .rom_dout     (rom_dout),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .halted       (halted),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'hA000_0000 + i;
        rom[5] = 32'hFFFF_FFFF;

        #1 rst_n = 1'b0;
        #11;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        chk("rst_romaddr", {22'd0, rom_addr}, 32'd0);
        rst_n = 1'b1;
        tick;

        out_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk("seq_valid0", {31'd0, out_valid}, 32'd1);
        chk("seq_pc0", out_pc, 32'h0);
        chk("seq_instr0", out_instr, 32'hA000_0000);
        for (int k = 1; k <= 2; k++) begin
            tick;
            chk("seq_pc", out_pc, 32'(4 * k));
            chk("seq_instr", out_instr, 32'hA000_0000 + 32'(k));
        end

        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_pc", out_pc, 32'h8);
            chk("stall_instr", out_instr, 32'hA000_0002);
            chk("stall_romaddr", {22'd0, rom_addr}, 32'd3);
        end
        out_ready = 1'b1;
        tick;
        chk("release_pc", out_pc, 32'hC);
        chk("release_instr", out_instr, 32'hA000_0003);
        tick;
        chk("pc16", out_pc, 32'h10);
        tick;
        chk("halt_pc", out_pc, 32'h14);
        chk("halt_instr", out_instr, 32'hFFFF_FFFF);
        chk("halt_valid", {31'd0, out_valid}, 32'd1);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        tick;
        chk("halt_drain", {31'd0, out_valid}, 32'd0);
        chk("halt_romaddr", {22'd0, rom_addr}, 32'd6);
        tick;
        chk("halt_nofetch", {31'd0, out_valid}, 32'd0);
        chk("halt_hold_pc", out_pc, 32'h14);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("resume_halted", {31'd0, halted}, 32'd0);
        tick;
        chk("resume_pc", out_pc, 32'h18);
        chk("resume_instr", out_instr, 32'hA000_0006);

        br_valid  = 1'b1;
        br_target = 32'h40;
        tick;
        br_valid = 1'b0;
        chk("br_flush", {31'd0, out_valid}, 32'd0);
        chk("br_romaddr", {22'd0, rom_addr}, 32'd16);
        tick;
        chk("br_valid", {31'd0, out_valid}, 32'd1);
        chk("br_pc", out_pc, 32'h40);
        chk("br_instr", out_instr, 32'hA000_0010);

        br_valid  = 1'b1;
        br_target = 32'h42;
        tick;
        br_valid = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        chk("mis_err", {31'd0, misalign_err}, 32'd1);
        chk("mis_halted", {31'd0, halted}, 32'd1);
        chk("mis_flush", {31'd0, out_valid}, 32'd0);
        chk("mis_pc_hold", {22'd0, rom_addr}, 32'd17);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk("mis_start_ign", {31'd0, halted}, 32'd1);
        chk("mis_nofetch", {31'd0, out_valid}, 32'd0);
`else
        chk("mis_err", {31'd0, misalign_err}, 32'd0);
        chk("mis_flush", {31'd0, out_valid}, 32'd0);
        chk("mis_romaddr", {22'd0, rom_addr}, 32'd16);
        tick;
        chk("mis_pc", out_pc, 32'h40);
        chk("mis_instr", out_instr, 32'hA000_0010);
`endif

        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        br_valid  = 1'b1;
        br_target = 32'hFFC;
        tick;
        br_valid = 1'b0;
        chk("wrap_romaddr1023", {22'd0, rom_addr}, 32'd1023);
        tick;
        chk("wrap_pc_ffc", out_pc, 32'hFFC);
        chk("wrap_instr", out_instr, 32'hA000_03FF);
        chk("wrap_romaddr0", {22'd0, rom_addr}, 32'd0);
        tick;
        chk("wrap_pc_1000", out_pc, 32'h1000);
        chk("wrap_instr0", out_instr, 32'hA000_0000);

        out_ready = 1'b0;
        tick;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_pc", out_pc, 32'h1000);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_pc", out_pc, 32'd0);
        chk("arst_instr", out_instr, 32'd0);
        chk("arst_romaddr", {22'd0, rom_addr}, 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
